// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined-adder result collector.
//   LAT_DEF   : adder register stages from operand capture to valid sum/cout
//   DEPTH_DEF : result FIFO entries (power of two, at least LAT_DEF+1)
//   TAG_W_DEF : operation tag width
//   result_t  : one collected result {tag, cout, sum} at the default tag width
package adder_pkg;

  localparam int LAT_DEF   = 5;
  localparam int DEPTH_DEF = 8;
  localparam int TAG_W_DEF = 4;
  localparam int SUM_W     = 32;

  typedef struct packed {
    logic [TAG_W_DEF-1:0] tag;
    logic                 cout;
    logic [SUM_W-1:0]     sum;
  } result_t;

  localparam int RESULT_W = $bits(result_t);

endpackage

// File: rtl/result_fifo.sv
// Result FIFO with first-word-fall-through behaviour and a registered head.
// Ports:
//   clk, clear_n : clock, synchronous active-low reset (pointers/count only)
//   push, wdata  : write wdata at the tail
//   pop          : drop the head (ignored when empty)
//   rdata        : head entry, valid while empty is low
//   full, empty  : status flags
//   count        : entries stored, 0..DEPTH
module result_fifo
  import adder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = RESULT_W
) (
  input  logic                   clk,
  input  logic                   clear_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count_reg;
  logic [W-1:0]  rdata_reg;
  logic          pop_ok;

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == (AW+1)'(DEPTH));
  assign count  = count_reg;
  assign rdata  = rdata_reg;
  assign pop_ok = pop & ~empty;

  // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap.
  assign rd_ptr_next = pop_ok ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Head register: read the entry that will be at the head after this edge.
  // When that entry is the one being written right now, take it from wdata
  // because the array still holds the old contents at that address.
  always_ff @(posedge clk) begin
    if (push && (wr_ptr_reg == rd_ptr_next)) begin
      rdata_reg <= wdata;
    end else begin
      rdata_reg <= mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/add_result_collector.sv
// Collects results of an external LAT-stage pipelined 32-bit adder into an
// in-order FIFO, handing out issue credits so the FIFO can never overflow.
// Ports:
//   clk, clear_n        : clock, synchronous active-low reset
//   issue_valid/tag     : operation issued to the adder this cycle
//   issue_ok            : credit available; issue only while high
//   sum, cout           : adder outputs, sampled when the tracked op arrives
//   res_valid/ready     : head-of-FIFO handshake
//   res_sum/cout/tag    : head result fields
//   occupancy           : FIFO entries stored
//   err_issue           : sticky, set by an issue attempted without credit
module add_result_collector
  import adder_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                   clk,
  input  logic                   clear_n,
  input  logic                   issue_valid,
  input  logic [TAG_W-1:0]       issue_tag,
  output logic                   issue_ok,
  input  logic [SUM_W-1:0]       sum,
  input  logic                   cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SUM_W-1:0]       res_sum,
  output logic                   res_cout,
  output logic [TAG_W-1:0]       res_tag,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err_issue
);

  localparam int REC_W = TAG_W + 1 + SUM_W;

  logic             issue_accept;
  logic [LAT-1:0]   valid_vec;
  logic             pop;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] fifo_wdata;
  logic [REC_W-1:0] fifo_rdata;
  logic             err_issue_reg;
  int               credit_used;

  assign issue_accept = issue_valid & issue_ok;

  // Valid/tag pipe shadowing the adder's register stages: stage LAT-1 is
  // valid exactly in the cycle the adder presents that op's sum/cout.
  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    logic             valid_reg;
    logic [TAG_W-1:0] tag_reg;
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (!clear_n) begin
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= issue_accept;
        end
        tag_reg <= issue_tag;
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (!clear_n) begin
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= g_stage[gi-1].valid_reg;
        end
        tag_reg <= g_stage[gi-1].tag_reg;
      end
    end
    assign valid_vec[gi] = valid_reg;
  end

  assign res_valid = ~fifo_empty;
  assign pop       = res_valid & res_ready;

  // Credits cover every op in the pipe plus every stored result, so a full
  // FIFO with ops still in flight cannot arise; the full term below is a
  // backstop that never blocks a write while the credits are respected.
  assign push       = valid_vec[LAT-1] & (~fifo_full | pop);
  assign fifo_wdata = {g_stage[LAT-1].tag_reg, cout, sum};

  // A pop this cycle frees a slot, so it may back an issue in the same cycle.
  always_comb begin
    credit_used = $countones(valid_vec) + int'(occupancy) - (pop ? 1 : 0);
    issue_ok    = (credit_used < DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      err_issue_reg <= 1'b0;
    end else if (issue_valid && !issue_ok) begin
      err_issue_reg <= 1'b1;
    end
  end

  assign err_issue = err_issue_reg;

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk     (clk),
    .clear_n (clear_n),
    .push    (push),
    .wdata   (fifo_wdata),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (occupancy)
  );

  assign res_tag  = fifo_rdata[REC_W-1 -: TAG_W];
  assign res_cout = fifo_rdata[SUM_W];
  assign res_sum  = fifo_rdata[SUM_W-1:0];

endmodule

// File: tb/tb_add_result_collector.sv
// Bench for add_result_collector: models the external pipelined adder,
// keeps a queue-based reference of every accepted op, and checks the DUT
// every cycle plus directed vectors and corner-case sequences.
module tb_add_result_collector;
  import adder_pkg::*;

  localparam int LAT   = LAT_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int TAG_W = TAG_W_DEF;

  logic                   clk = 1'b0;
  logic                   clear_n;
  logic                   issue_valid;
  logic [TAG_W-1:0]       issue_tag;
  logic                   issue_ok;
  logic [31:0]            sum;
  logic                   cout;
  logic                   res_valid;
  logic                   res_ready;
  logic [31:0]            res_sum;
  logic                   res_cout;
  logic [TAG_W-1:0]       res_tag;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   err_issue;
  logic [31:0]            a;
  logic [31:0]            b;

  always #5 clk = ~clk;

  add_result_collector #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .issue_valid (issue_valid),
    .issue_tag   (issue_tag),
    .issue_ok    (issue_ok),
    .sum         (sum),
    .cout        (cout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_cout    (res_cout),
    .res_tag     (res_tag),
    .occupancy   (occupancy),
    .err_issue   (err_issue)
  );

  // External adder: operands captured at the edge, result after LAT stages.
  logic [32:0] add_pipe [LAT];
  always @(posedge clk) begin
    add_pipe[0] <= {1'b0, a} + {1'b0, b};
    for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign sum  = add_pipe[LAT-1][31:0];
  assign cout = add_pipe[LAT-1][32];

  // Reference: every accepted op with the cycle its result becomes visible.
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [32:0]      val;
    int               ready;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  bit   model_on = 0;
  bit   m_err = 0;
  bit   pend_accept, pend_pop, pend_err;
  exp_t pend_item;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, expv);
    end
  endtask

  function automatic bit model_valid();
    return (q.size() > 0) && (q[0].ready <= cyc);
  endfunction

  function automatic bit model_ok();
    int used;
    used = q.size() - ((model_valid() && res_ready) ? 1 : 0);
    return used < DEPTH;
  endfunction

  task automatic check_cycle();
    int occ;
    bit mv, mok;
    occ = 0;
    foreach (q[i]) if (q[i].ready <= cyc) occ++;
    mv  = model_valid();
    mok = model_ok();
    chk("res_valid", res_valid, mv);
    chk("occupancy", occupancy, occ);
    chk("no_overflow", occupancy <= DEPTH, 1);
    chk("issue_ok", issue_ok, mok);
    chk("err_issue", err_issue, m_err);
    if (mv) begin
      chk("res_sum", res_sum, q[0].val[31:0]);
      chk("res_cout", res_cout, q[0].val[32]);
      chk("res_tag", res_tag, q[0].tag);
    end
    pend_pop      = mv && res_ready;
    pend_accept   = issue_valid && mok;
    pend_err      = issue_valid && !mok;
    pend_item.tag = issue_tag;
    pend_item.val = {1'b0, a} + {1'b0, b};
    pend_item.ready = cyc + LAT + 1;
  endtask

  // One clock cycle: check at the negedge, advance the model at the posedge.
  task automatic cycle();
    @(negedge clk);
    if (model_on) check_cycle();
    else begin
      pend_accept = 0; pend_pop = 0; pend_err = 0;
    end
    @(posedge clk);
    if (!clear_n) begin
      q.delete();
      m_err = 0;
    end else begin
      if (pend_pop) void'(q.pop_front());
      if (pend_accept) q.push_back(pend_item);
      if (pend_err) m_err = 1;
    end
    cyc++;
    #1;
  endtask

  task automatic set_issue(input bit v, input logic [TAG_W-1:0] t);
    issue_valid = v;
    issue_tag   = t;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic do_reset();
    clear_n = 0;
    issue_valid = 0;
    cycle();
    clear_n = 1;
    chk("rst_valid", res_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_err", err_issue, 0);
    chk("rst_ok", issue_ok, 1);
  endtask

  task automatic fill8();
    res_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_ok", issue_ok, 1);
      set_issue(1, TAG_W'(i));
      cycle();
    end
    issue_valid = 0;
    chk("full_credit", issue_ok, 0);
    for (int k = 0; k <= LAT; k++) cycle();
    chk("occ_full", occupancy, DEPTH);
    chk("full_no_ok", issue_ok, 0);
  endtask

  task automatic drain8();
    res_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", res_valid, 1);
      chk("drain_tag", res_tag, TAG_W'(i));
      cycle();
    end
    res_ready = 0;
    chk("drained", res_valid, 0);
  endtask

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_sum;
    logic             exp_cout;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd3,  32'h0000_0000, 1'b1};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 4'd5,  32'h8000_0000, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 4'd9,  32'h0000_0000, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'hFFFF_FFFE, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 4'd0,  32'h2345_6789, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 4'd10, 32'h0000_0000, 1'b0};

    clear_n = 0; issue_valid = 0; issue_tag = '0; res_ready = 0; a = '0; b = '0;
    cycle();
    cycle();
    clear_n = 1;
    model_on = 1;
    chk("rst_valid", res_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_err", err_issue, 0);
    chk("rst_ok", issue_ok, 1);

    // Directed single ops: exact latency and field values.
    foreach (vecs[v]) begin
      res_ready = 0;
      issue_valid = 1; issue_tag = vecs[v].tag; a = vecs[v].a; b = vecs[v].b;
      cycle();
      set_issue(0, '0);
      for (int k = 1; k <= LAT; k++) begin
        chk("lat_early", res_valid, 0);
        cycle();
      end
      chk("lat_valid", res_valid, 1);
      chk("vec_sum", res_sum, vecs[v].exp_sum);
      chk("vec_cout", res_cout, vecs[v].exp_cout);
      chk("vec_tag", res_tag, vecs[v].tag);
      $display("vec %0d: a=%h b=%h tag=%0d -> sum=%h cout=%0d tag=%0d",
               v, vecs[v].a, vecs[v].b, vecs[v].tag, res_sum, res_cout, res_tag);
      res_ready = 1;
      cycle();
      res_ready = 0;
    end

    // Back-to-back fill to full, then in-order drain.
    fill8();
    drain8();
    $display("fill/drain of %0d ops done", DEPTH);

    // Issue without credit: dropped, sticky error until reset.
    fill8();
    issue_valid = 1; issue_tag = 4'hE; a = $urandom; b = $urandom;
    chk("blocked_ok", issue_ok, 0);
    cycle();
    issue_valid = 0;
    chk("err_set", err_issue, 1);
    drain8();
    res_ready = 1;
    for (int k = 0; k < LAT + 3; k++) begin
      chk("no_dropped", res_valid, 0);
      chk("err_sticky", err_issue, 1);
      cycle();
    end
    do_reset();
    $display("illegal issue dropped, err_issue cleared by reset");

    // Steady stream: one result per cycle, occupancy 1, credit always there.
    res_ready = 1;
    for (int i = 0; i < 30; i++) begin
      set_issue(1, TAG_W'(i));
      if (i > LAT) begin
        chk("stream_valid", res_valid, 1);
        chk("stream_occ", occupancy, 1);
        chk("stream_ok", issue_ok, 1);
      end
      cycle();
    end
    set_issue(0, '0);
    for (int k = 0; k < LAT + 2; k++) cycle();
    chk("stream_empty", res_valid, 0);
    $display("steady stream of 30 ops done");

    // Reset with 3 ops in flight and 2 buffered.
    res_ready = 0;
    for (int i = 0; i < 5; i++) begin
      set_issue(1, TAG_W'(i + 1));
      cycle();
    end
    set_issue(0, '0);
    cycle();
    cycle();
    chk("mid_occ", occupancy, 2);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      res_ready = 1'($urandom);
      a = $urandom; b = $urandom;
      chk("stale_valid", res_valid, 0);
      chk("stale_occ", occupancy, 0);
      cycle();
    end
    $display("mid-operation reset discarded pipe and FIFO");

    // Random traffic with alternating drain-heavy and backpressure phases.
    for (int c = 0; c < 10000; c++) begin
      if ((c / 500) % 2 == 0) res_ready = ($urandom_range(0, 3) != 0);
      else                    res_ready = ($urandom_range(0, 3) == 0);
      set_issue(model_ok() && ($urandom_range(0, 3) != 0), TAG_W'($urandom));
      cycle();
    end
    set_issue(0, '0);
    res_ready = 1;
    for (int k = 0; k < DEPTH + LAT + 4; k++) cycle();
    chk("rand_empty", res_valid, 0);
    chk("rand_occ", occupancy, 0);
    $display("random traffic of 10000 cycles done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
